// File: rtl/output_misr.sv
// Output MISR: folds 245-bit result words into a 32-bit signature over a
// fixed number of valid samples and compares it against a golden value.
// Ports:
//   clk, rst (async, active-high)
//   y[244:0], y_valid : sample input
//   start             : begins/restarts a run
//   expected[31:0]    : golden signature, sampled at completion
//   sig, sample_cnt, max_stable : signature and run statistics
//   busy, done, match : run status
module output_misr #(
  parameter int unsigned NUM_SAMPLES = 21,
  parameter logic [31:0] SEED = 32'h0000_0000,
  parameter logic [31:0] POLY = 32'h04C1_1DB7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [244:0] y,
  input  logic         y_valid,
  input  logic         start,
  input  logic [31:0]  expected,
  output logic [31:0]  sig,
  output logic [7:0]   sample_cnt,
  output logic [7:0]   max_stable,
  output logic         busy,
  output logic         done,
  output logic         match
);

  localparam logic [7:0] LAST = 8'(NUM_SAMPLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [31:0]  sig_nxt;
  logic [7:0]   cnt_nxt, max_nxt;
  logic [7:0]   run_len, len_nxt;
  logic [244:0] last_y, last_nxt;
  logic         match_nxt;

  logic [31:0]  fold;
  logic [31:0]  sig_upd;
  logic [7:0]   cnt_inc;
  logic [7:0]   len_upd;

  always_comb begin
    fold = {11'b0, y[244:224]};
    for (int k = 0; k < 7; k++) begin
      fold = fold ^ y[32*k +: 32];
    end
  end

  assign sig_upd = {sig[30:0], 1'b0}
                 ^ (sig[31] ? POLY : 32'h0)
                 ^ fold;
  assign cnt_inc = sample_cnt + 8'd1;

  // First sample of a run starts a stable streak of one; the streak
  // saturates so max_stable never wraps.
  always_comb begin
    len_upd = 8'd1;
    if (sample_cnt != 8'd0 && y == last_y) begin
      len_upd = (run_len == 8'hFF) ? 8'hFF : run_len + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    sig_nxt   = sig;
    cnt_nxt   = sample_cnt;
    max_nxt   = max_stable;
    len_nxt   = run_len;
    last_nxt  = last_y;
    match_nxt = match;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          sig_nxt   = SEED;
          cnt_nxt   = 8'd0;
          max_nxt   = 8'd0;
          len_nxt   = 8'd0;
          match_nxt = 1'b0;
        end
      end
      RUN: begin
        if (start) begin
          sig_nxt   = SEED;
          cnt_nxt   = 8'd0;
          max_nxt   = 8'd0;
          len_nxt   = 8'd0;
          match_nxt = 1'b0;
        end else if (y_valid) begin
          sig_nxt  = sig_upd;
          cnt_nxt  = cnt_inc;
          last_nxt = y;
          len_nxt  = len_upd;
          max_nxt  = (len_upd > max_stable) ? len_upd : max_stable;
          if (cnt_inc == LAST) begin
            state_nxt = DONE;
            match_nxt = (sig_upd == expected);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sig        <= SEED;
      sample_cnt <= 8'd0;
      max_stable <= 8'd0;
      run_len    <= 8'd0;
      last_y     <= '0;
      match      <= 1'b0;
    end else begin
      state      <= state_nxt;
      sig        <= sig_nxt;
      sample_cnt <= cnt_nxt;
      max_stable <= max_nxt;
      run_len    <= len_nxt;
      last_y     <= last_nxt;
      match      <= match_nxt;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_output_misr.sv
// Testbench for output_misr: three instances (1, 2 and 21 samples) share
// stimulus; results are checked against a queue-based signature model.
module tb_output_misr;

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic         clk;
  logic         rst;
  logic [244:0] y;
  logic         y_valid;
  logic         start;
  logic [31:0]  expected;

  logic [31:0] sig1, sig2, sig21;
  logic [7:0]  cnt1, cnt2, cnt21;
  logic [7:0]  max1, max2, max21;
  logic        busy1, busy2, busy21;
  logic        done1, done2, done21;
  logic        match1, match2, match21;

  int tests;
  int fails;
  logic [50:0] got, want;
  logic [244:0] q[$];

  output_misr #(.NUM_SAMPLES(1)) dut1 (
    .clk(clk), .rst(rst), .y(y), .y_valid(y_valid),
    .start(start), .expected(expected),
    .sig(sig1), .sample_cnt(cnt1), .max_stable(max1),
    .busy(busy1), .done(done1), .match(match1)
  );

  output_misr #(.NUM_SAMPLES(2)) dut2 (
    .clk(clk), .rst(rst), .y(y), .y_valid(y_valid),
    .start(start), .expected(expected),
    .sig(sig2), .sample_cnt(cnt2), .max_stable(max2),
    .busy(busy2), .done(done2), .match(match2)
  );

  output_misr #(.NUM_SAMPLES(21)) dut21 (
    .clk(clk), .rst(rst), .y(y), .y_valid(y_valid),
    .start(start), .expected(expected),
    .sig(sig21), .sample_cnt(cnt21), .max_stable(max21),
    .busy(busy21), .done(done21), .match(match21)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [50:0] st1();
    return {sig1, cnt1, max1, busy1, done1, match1};
  endfunction

  function automatic logic [50:0] st2();
    return {sig2, cnt2, max2, busy2, done2, match2};
  endfunction

  function automatic logic [50:0] st21();
    return {sig21, cnt21, max21, busy21, done21, match21};
  endfunction

  function automatic logic [244:0] rand_y();
    logic [255:0] t;
    for (int k = 0; k < 8; k++) t[32*k +: 32] = $urandom;
    return t[244:0];
  endfunction

  // Reference: zero-extend to eight 32-bit words and XOR them together.
  function automatic logic [31:0] fold_ref(logic [244:0] v);
    logic [255:0] z;
    logic [31:0]  f;
    z = {11'b0, v};
    f = 32'h0;
    for (int k = 0; k < 8; k++) f = f ^ z[32*k +: 32];
    return f;
  endfunction

  function automatic logic [31:0] model_sig();
    logic [31:0] s;
    s = 32'h0;
    foreach (q[i]) begin
      s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ fold_ref(q[i]);
    end
    return s;
  endfunction

  function automatic logic [7:0] model_max();
    int run, best;
    run = 0;
    best = 0;
    foreach (q[i]) begin
      run = (i > 0 && q[i] == q[i-1]) ? run + 1 : 1;
      if (run > best) best = run;
    end
    return (best > 255) ? 8'hFF : 8'(best);
  endfunction

  // Start pulse with a junk valid sample alongside, which must be ignored.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    y = rand_y();
    y_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    y_valid = 1'b0;
  endtask

  task automatic feed(input logic [244:0] v, input int gap);
    y_valid = 1'b0;
    repeat (gap) @(negedge clk);
    y = v;
    y_valid = 1'b1;
    @(negedge clk);
    y_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    tests++;
    got = st21();
    want = '0;
    if (got !== want) begin
      fails++;
      $display("FAIL reset_state got=%h want=%h", got, want);
    end
    @(negedge clk);
    rst = 1'b0;
    y = rand_y();
    y_valid = 1'b1;
    repeat (4) @(negedge clk);
    y_valid = 1'b0;
    tests++;
    got = {st1(), st21()};
    want = '0;
    if ({st1(), st21()} !== 102'd0) begin
      fails++;
      $display("FAIL idle_hold got=%h want=0", {st1(), st21()});
    end
  endtask

  task automatic test_single();
    pulse_start();
    expected = 32'h1;
    feed(245'h1, 0);
    tests++;
    got = st1();
    want = {32'h1, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1};
    if (got !== want) begin
      fails++;
      $display("FAIL single_one got=%h want=%h", got, want);
    end
    pulse_start();
    expected = 32'h0;
    feed({21'h1, 192'b0, 32'h1}, 1);
    tests++;
    got = st1();
    want = {32'h0, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1};
    if (got !== want) begin
      fails++;
      $display("FAIL fold_alias got=%h want=%h", got, want);
    end
  endtask

  task automatic test_two();
    pulse_start();
    expected = 32'h3;
    feed(245'h1, 0);
    tests++;
    got = st2();
    want = {32'h1, 8'd1, 8'd1, 1'b1, 1'b0, 1'b0};
    if (got !== want) begin
      fails++;
      $display("FAIL two_first got=%h want=%h", got, want);
    end
    feed(245'h0, 2);
    tests++;
    got = st2();
    want = {32'h2, 8'd2, 8'd1, 1'b0, 1'b1, 1'b0};
    if (got !== want) begin
      fails++;
      $display("FAIL two_nomatch got=%h want=%h", got, want);
    end
    pulse_start();
    expected = 32'h04C1_1DB7;
    feed(245'h8000_0000, 0);
    feed(245'h0, 0);
    tests++;
    got = st2();
    want = {32'h04C1_1DB7, 8'd2, 8'd1, 1'b0, 1'b1, 1'b1};
    if (got !== want) begin
      fails++;
      $display("FAIL msb_feedback got=%h want=%h", got, want);
    end
  endtask

  task automatic test_gaps();
    pulse_start();
    expected = 32'h0;
    for (int i = 1; i <= 21; i++) begin
      feed(245'h0, $urandom_range(0, 3));
      if (i == 20) begin
        tests++;
        if ({busy21, done21, cnt21} !== {1'b1, 1'b0, 8'd20}) begin
          fails++;
          $display("FAIL gaps_pre got=%h want=%h",
                   {busy21, done21, cnt21}, {1'b1, 1'b0, 8'd20});
        end
      end
    end
    tests++;
    got = st21();
    want = {32'h0, 8'd21, 8'd21, 1'b0, 1'b1, 1'b1};
    if (got !== want) begin
      fails++;
      $display("FAIL gaps_final got=%h want=%h", got, want);
    end
    expected = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) feed(rand_y(), 0);
    tests++;
    if (st21() !== want) begin
      fails++;
      $display("FAIL done_hold got=%h want=%h", st21(), want);
    end
  endtask

  task automatic run_random(input string name, input bit want_match);
    logic [31:0] ms;
    q.delete();
    for (int i = 0; i < 21; i++) begin
      if (q.size() > 0 && $urandom_range(0, 1) == 1) q.push_back(q[$]);
      else q.push_back(rand_y());
    end
    ms = model_sig();
    expected = want_match ? ms : ms ^ 32'h8000_0001;
    foreach (q[i]) begin
      feed(q[i], $urandom_range(0, 2));
      if (i == 19) begin
        tests++;
        if ({busy21, done21} !== 2'b10) begin
          fails++;
          $display("FAIL %s_pre got=%b want=10", name, {busy21, done21});
        end
      end
    end
    tests++;
    got = st21();
    want = {ms, 8'd21, model_max(), 1'b0, 1'b1, want_match};
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      pulse_start();
      run_random("random", it[0]);
    end
  endtask

  task automatic test_restart();
    pulse_start();
    for (int i = 0; i < 4; i++) feed(rand_y(), 0);
    pulse_start();
    tests++;
    got = st21();
    want = {32'h0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0};
    if (got !== want) begin
      fails++;
      $display("FAIL restart_clear got=%h want=%h", got, want);
    end
    run_random("restart_run", 1'b1);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    for (int i = 0; i < 5; i++) feed(rand_y(), 0);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    got = st21();
    want = '0;
    if (got !== want) begin
      fails++;
      $display("FAIL reset_async got=%h want=%h", got, want);
    end
    @(negedge clk);
    rst = 1'b0;
    y = rand_y();
    y_valid = 1'b1;
    repeat (25) @(negedge clk);
    y_valid = 1'b0;
    tests++;
    if (st21() !== 51'd0) begin
      fails++;
      $display("FAIL reset_no_done got=%h want=0", st21());
    end
    pulse_start();
    run_random("after_reset", 1'b1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    y = '0;
    y_valid = 1'b0;
    start = 1'b0;
    expected = 32'h0;
    test_reset();
    test_single();
    test_two();
    test_gaps();
    test_random();
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/output_misr.md
OUTPUT_MISR -- requirements
Module: output_misr

Parameters
REQ-001 SHALL have parameter NUM_SAMPLES, default 21: number of valid samples compacted per run, legal range 1..255.
REQ-002 SHALL have parameter SEED, default 32'h0000_0000: signature value loaded at start.
REQ-003 SHALL have parameter POLY, default 32'h04C1_1DB7: MISR feedback polynomial.

Interface
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port y, input, 245 bits [244:0]: result word from the design-under-test stage, sampled when y_valid=1.
REQ-007 SHALL have port y_valid, input, 1 bit: y is valid this cycle.
REQ-008 SHALL have port start, input, 1 bit: single-cycle pulse that begins a run.
REQ-009 SHALL have port expected, input, 32 bits: golden signature; sampled only in the cycle the run completes.
REQ-010 SHALL have port sig, output, 32 bits: current signature register.
REQ-011 SHALL have port sample_cnt, output, 8 bits: valid samples absorbed in the current or last run.
REQ-012 SHALL have port max_stable, output, 8 bits: longest run of consecutive identical valid samples.
REQ-013 SHALL have port busy, output, 1 bit: high in state RUN.
REQ-014 SHALL have port done, output, 1 bit: high in state DONE.
REQ-015 SHALL have port match, output, 1 bit: sig equalled expected at completion; meaningful only when done=1.

Function
REQ-016 SHALL compute fold(y) as the XOR of y[31:0], y[63:32], y[95:64], y[127:96], y[159:128], y[191:160], y[223:192] and {11'b0, y[244:224]}.
REQ-017 SHALL update sig on each RUN cycle with y_valid=1 as {sig[30:0],1'b0} XOR (sig[31] ? POLY : 0) XOR fold(y).
REQ-018 SHALL implement three states: IDLE, RUN and DONE.
REQ-019 In IDLE or DONE, start=1 SHALL load sig=SEED, sample_cnt=0, max_stable=0 and current-run length=0, clear done and match, and enter RUN next cycle; y_valid is ignored in that cycle.
REQ-020 In RUN, start=1 SHALL restart the run exactly as REQ-019, take priority over y_valid, and stay in RUN.
REQ-021 In RUN, a y_valid=1 cycle SHALL increment sample_cnt by 1.
REQ-022 In RUN, a y_valid=1 cycle SHALL also store y as last_y.
REQ-023 Current-run length SHALL be 1 on the first sample of a run, increment when y equals last_y, and reset to 1 otherwise.
REQ-024 max_stable SHALL hold the maximum current-run length, saturating at 255.
REQ-025 The valid sample that makes sample_cnt reach NUM_SAMPLES SHALL move to DONE next cycle with done=1, busy=0 and match = (updated sig == expected).
REQ-026 In DONE, sig, sample_cnt, max_stable and match SHALL hold until start or rst.
REQ-027 In RUN, y_valid=0 cycles SHALL leave all registers unchanged; gaps of any length are legal.
REQ-028 In IDLE and DONE, y_valid SHALL be ignored.
REQ-029 Completion latency SHALL be 1 cycle: done rises on the clk edge that absorbs the final sample.

Reset
REQ-030 Assertion of rst SHALL immediately force state IDLE, sig=SEED, sample_cnt=0, max_stable=0, last_y=0, busy=0, done=0 and match=0, independent of clk.
REQ-031 rst asserted mid-run SHALL abandon the run with no done pulse.
REQ-032 After rst deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-033 Bench SHALL cover: NUM_SAMPLES=1, SEED=0, start, then y=1 with y_valid=1 and expected=1 -> sig=32'h1, sample_cnt=1, done=1, match=1 on that edge.
REQ-034 Bench SHALL cover: NUM_SAMPLES=2, y=1 then y=0, expected=3 -> sig=32'h2, done=1, match=0, max_stable=1.
REQ-035 Bench SHALL cover: NUM_SAMPLES=21, 21 all-zero samples with y_valid gaps of 0-3 cycles -> sig=0, sample_cnt=21, max_stable=21, busy falling exactly when done rises.
REQ-036 Bench SHALL cover the MSB-feedback path: NUM_SAMPLES=2, y[31]=1 then y=0 -> sig=32'h04C11DB7.
REQ-037 Bench SHALL cover fold aliasing: NUM_SAMPLES=1, y={21'h1, 192'b0, 32'h1} -> sig=0.
REQ-038 Bench SHALL cover: rst asserted after 5 of 21 samples -> outputs reach their REQ-030 values before the next clk edge; a subsequent start with 21 samples completes normally.
